box_draw: RTL and testbench
===========================

BOX_DRAW -- requirements
Module: box_draw

Interface
REQ-001 Parameters SHALL be: WIDTH, 768, image width in pixels; HEIGHT, 512, image height in pixels; ADDR_W, 19, RAM word-address width; PIX_W, 24, RGB pixel width.
REQ-002 CLOCK_50  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to draw a box.
REQ-005 x_min, x_max  input  $clog2(WIDTH)  box column bounds, inclusive.
REQ-006 y_min, y_max  input  $clog2(HEIGHT)  box row bounds, inclusive.
REQ-007 colour  input  PIX_W  pixel value written.
REQ-008 fill  input  1  1 = filled rectangle (only honoured per REQ-027).
REQ-009 wr_ready  input  1  RAM accepts the current write.
REQ-010 wr_en, wr_addr, wr_data  output  1/ADDR_W/PIX_W  RAM write port, all registered.
REQ-011 busy, done, err  output  1/1/1  draw in progress; one-cycle completion pulse; one-cycle rejection flag.

Function
REQ-012 Pixel (x,y) SHALL map to wr_addr = y*WIDTH + x, computed without truncation in ADDR_W bits.
REQ-013 States SHALL be IDLE, TOP, BOTTOM, LEFT, RIGHT, FILL, DONE.
REQ-014 start SHALL be sampled only in IDLE; coords, colour and fill latched on that edge; start while busy=1 ignored.
REQ-015 Latency: start sampled at edge N -> wr_en=1 with the first pixel after edge N, busy=1 from same edge.
REQ-016 A write SHALL complete only on a cycle with wr_en=1 and wr_ready=1; while wr_ready=0, wr_addr/wr_data held stable and wr_en stays 1.
REQ-017 Outline order: TOP row y_min, x_min..x_max; BOTTOM row y_max, x_min..x_max; LEFT column x_min, y_min+1..y_max-1; RIGHT column x_max, y_min+1..y_max-1; each ascending.
REQ-018 BOTTOM SHALL be skipped when y_min==y_max; LEFT/RIGHT skipped when y_max-y_min<2; RIGHT skipped when x_min==x_max; no pixel written twice.
REQ-019 Outline writes SHALL total w*(h>1?2:1) + (h>2?(h-2)*(w>1?2:1):0), where w=x_max-x_min+1, h=y_max-y_min+1.
REQ-020 FILL SHALL write rows y_min..y_max, each x_min..x_max, raster order, w*h writes.
REQ-021 One completed write per cycle max; back-to-back writes with wr_ready=1 have no idle cycles between pixels or states.
REQ-022 After the last completed write: DONE for one cycle, wr_en=0, done=1, busy=0; then IDLE.
REQ-023 Invalid request (x_min>x_max, y_min>y_max, x_max>=WIDTH, or y_max>=HEIGHT): no writes; done=1 and err=1 for one cycle, one cycle after start; busy stays 0.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE; wr_en, wr_addr, wr_data, busy, done, err all 0.
REQ-025 reset mid-draw SHALL abort; no further writes; aborted draw not resumed; done not pulsed.
REQ-026 reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro BOX_DRAW_FILL_EN: defined -> fill=1 selects FILL path per REQ-020; undefined -> FILL state and its logic absent, fill input ignored, always outline.

Verification
REQ-028 Box (10,20)-(12,22) outline, colour FF0000, wr_ready=1 -> 8 writes, addr 15370,15371,15372,16906,16907,16908,16138,16140, data FF0000; done on cycle after 8th write.
REQ-029 Box (5,5)-(5,5) -> one write addr 3845; done next cycle; err=0.
REQ-030 Box (0,0)-(3,0) with wr_ready low 3 cycles during 2nd write -> addr 1 held 4 cycles; sequence 0,1,2,3 with no skip or repeat.
REQ-031 x_min=20,x_max=10 -> err=done=1 one cycle, zero writes; x_max=768 -> same.
REQ-032 reset raised during LEFT of (0,0)-(9,9) -> next cycle wr_en=0, busy=0, done=0; subsequent start of (1,1)-(1,1) writes addr 769 only.
REQ-033 Box (0,0)-(2,2), fill=1: with BOX_DRAW_FILL_EN -> 9 writes 0,1,2,768,769,770,1536,1537,1538; without -> 8 writes, addr 769 never written.

Source files
------------

// File: rtl/box_draw.sv
// Rectangle rasteriser: writes an outlined (or, with BOX_DRAW_FILL_EN defined,
// optionally filled) box into a WIDTH x HEIGHT RGB frame buffer, one pixel per accepted write.
module box_draw #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 24
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(WIDTH)-1:0]  x_min,
    input  logic [$clog2(WIDTH)-1:0]  x_max,
    input  logic [$clog2(HEIGHT)-1:0] y_min,
    input  logic [$clog2(HEIGHT)-1:0] y_max,
    input  logic [PIX_W-1:0]          colour,
    input  logic                      fill,
    input  logic                      wr_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [PIX_W-1:0]          wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

`ifdef BOX_DRAW_FILL_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_TOP = 3'd1, S_BOTTOM = 3'd2, S_LEFT = 3'd3,
        S_RIGHT = 3'd4, S_FILL = 3'd5, S_DONE = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_TOP = 3'd1, S_BOTTOM = 3'd2, S_LEFT = 3'd3,
        S_RIGHT = 3'd4, S_DONE = 3'd6
    } state_t;
    logic unused_fill_s;
    assign unused_fill_s = fill;
`endif

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0]       y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic                wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]    wr_data_q, wr_data_d;
    logic                req_ok_s, advance_s, finish_s;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [XW-1:0] px, input logic [YW-1:0] py);
        pix_addr = ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);
    endfunction

    assign req_ok_s  = (x_min <= x_max) && (y_min <= y_max) &&
                       (32'(x_max) < WIDTH) && (32'(y_max) < HEIGHT);
    assign advance_s = wr_en_q && wr_ready;

    // Next-state, next-pixel and output computation
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        finish_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && req_ok_s) begin
                    xmin_d    = x_min;
                    xmax_d    = x_max;
                    ymin_d    = y_min;
                    ymax_d    = y_max;
                    x_d       = x_min;
                    y_d       = y_min;
                    wr_data_d = colour;
                    wr_en_d   = 1'b1;
                    busy_d    = 1'b1;
`ifdef BOX_DRAW_FILL_EN
                    state_d   = fill ? S_FILL : S_TOP;
`else
                    state_d   = S_TOP;
`endif
                end else if (start) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TOP: begin
                if (!advance_s) begin
                    state_d = S_TOP;
                end else if (x_q != xmax_q) begin
                    x_d = x_q + XW'(1);
                end else if (ymin_q != ymax_q) begin
                    state_d = S_BOTTOM;
                    x_d     = xmin_q;
                    y_d     = ymax_q;
                end else begin
                    finish_s = 1'b1;
                end
            end
            S_BOTTOM: begin
                // Side columns exist only when at least one row lies between top and bottom
                if (!advance_s) begin
                    state_d = S_BOTTOM;
                end else if (x_q != xmax_q) begin
                    x_d = x_q + XW'(1);
                end else if ((ymax_q - ymin_q) >= YW'(2)) begin
                    state_d = S_LEFT;
                    x_d     = xmin_q;
                    y_d     = ymin_q + YW'(1);
                end else begin
                    finish_s = 1'b1;
                end
            end
            S_LEFT: begin
                if (!advance_s) begin
                    state_d = S_LEFT;
                end else if (y_q != ymax_q - YW'(1)) begin
                    y_d = y_q + YW'(1);
                end else if (xmin_q != xmax_q) begin
                    state_d = S_RIGHT;
                    x_d     = xmax_q;
                    y_d     = ymin_q + YW'(1);
                end else begin
                    finish_s = 1'b1;
                end
            end
            S_RIGHT: begin
                if (!advance_s) begin
                    state_d = S_RIGHT;
                end else if (y_q != ymax_q - YW'(1)) begin
                    y_d = y_q + YW'(1);
                end else begin
                    finish_s = 1'b1;
                end
            end
`ifdef BOX_DRAW_FILL_EN
            S_FILL: begin
                if (!advance_s) begin
                    state_d = S_FILL;
                end else if (x_q != xmax_q) begin
                    x_d = x_q + XW'(1);
                end else if (y_q != ymax_q) begin
                    x_d = xmin_q;
                    y_d = y_q + YW'(1);
                end else begin
                    finish_s = 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        if (finish_s) begin
            state_d = S_DONE;
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end else begin
            done_d = done_d;
        end
        wr_addr_d = pix_addr(x_d, y_d);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymin_q    <= '0;
            ymax_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_box_draw.sv
// Directed bench for box_draw: outline, single pixel, back-pressure, invalid
// requests, reset abort/priority, ignored start while busy and the fill option.
module tb_box_draw;
    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1, start = 1'b0, fill = 1'b0, wr_ready = 1'b1;
    logic [9:0]  x_min = 10'd0, x_max = 10'd0;
    logic [8:0]  y_min = 9'd0, y_max = 9'd0;
    logic [23:0] colour = 24'd0;
    logic        wr_en, busy, done, err;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;

    int n_pass = 0, n_total = 0;
    int wa[$];
    logic [23:0] wd[$];
    int obs[$];
    int last_wr_cyc, done_cyc;
    bit got_done, got_err, busy_bad;

    box_draw dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .colour(colour), .fill(fill), .wr_ready(wr_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic do_start(input int x0, input int x1, input int y0, input int y1,
                            input logic [23:0] c, input logic f);
        @(negedge CLOCK_50);
        x_min = 10'(x0); x_max = 10'(x1); y_min = 9'(y0); y_max = 9'(y1);
        colour = c; fill = f; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    // Records accepted writes until done, optionally stalling wr_ready at one write
    task automatic collect(input int stall_idx, input int stall_len);
        int rem = stall_len;
        int cyc = 0;
        wa.delete(); wd.delete(); obs.delete();
        got_done = 1'b0; got_err = 1'b0; busy_bad = 1'b0;
        last_wr_cyc = -1; done_cyc = -1;
        while (cyc < 300) begin
            if (wr_en && wa.size() == stall_idx && rem > 0) begin
                wr_ready = 1'b0; rem--;
            end else begin
                wr_ready = 1'b1;
            end
            if (done) begin
                got_done = 1'b1; got_err = err; done_cyc = cyc;
                if (busy || wr_en) busy_bad = 1'b1;
                break;
            end
            if (wr_en) begin
                obs.push_back(int'(wr_addr));
                if (!busy) busy_bad = 1'b1;
            end
            if (wr_en && wr_ready) begin
                wa.push_back(int'(wr_addr)); wd.push_back(wr_data); last_wr_cyc = cyc;
            end
            @(negedge CLOCK_50);
            start = 1'b0;
            cyc++;
        end
        wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLOCK_50);
        n_total++; if ({wr_en, busy, done, err} !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", {wr_en, busy, done, err}); else n_pass++;
        n_total++; if (wr_addr !== 19'd0 || wr_data !== 24'd0) $display("FAIL reset_bus got addr=%0d data=%h exp=0/0", wr_addr, wr_data); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_outline();
        int exp_a[8] = '{15370, 15371, 15372, 16906, 16907, 16908, 16138, 16140};
        do_start(10, 12, 20, 22, 24'hFF0000, 1'b0);
        collect(-1, 0);
        n_total++; if (got_done !== 1'b1 || got_err !== 1'b0) $display("FAIL outline_done got done=%0d err=%0d exp=1/0", got_done, got_err); else n_pass++;
        n_total++; if (wa.size() !== 8) $display("FAIL outline_count got=%0d exp=8", wa.size()); else n_pass++;
        for (int i = 0; i < 8 && i < wa.size(); i++) begin
            n_total++; if (wa[i] !== exp_a[i] || wd[i] !== 24'hFF0000) $display("FAIL outline_wr%0d got=%0d/%h exp=%0d/ff0000", i, wa[i], wd[i], exp_a[i]); else n_pass++;
        end
        n_total++; if (last_wr_cyc !== 7 || done_cyc !== 8) $display("FAIL outline_timing got last=%0d done=%0d exp=7/8", last_wr_cyc, done_cyc); else n_pass++;
        n_total++; if (busy_bad !== 1'b0) $display("FAIL outline_busy got=%0d exp=0", busy_bad); else n_pass++;
        @(negedge CLOCK_50);
        n_total++; if ({done, busy, wr_en} !== 3'b000) $display("FAIL outline_idle got=%b exp=000", {done, busy, wr_en}); else n_pass++;
    endtask

    task automatic test_single();
        do_start(5, 5, 5, 5, 24'h00A5C3, 1'b0);
        collect(-1, 0);
        n_total++; if (wa.size() !== 1) $display("FAIL single_count got=%0d exp=1", wa.size()); else n_pass++;
        n_total++; if (wa.size() > 0 && (wa[0] !== 3845 || wd[0] !== 24'h00A5C3)) $display("FAIL single_addr got=%0d/%h exp=3845/00a5c3", wa[0], wd[0]); else n_pass++;
        n_total++; if (done_cyc !== 1 || got_err !== 1'b0) $display("FAIL single_done got cyc=%0d err=%0d exp=1/0", done_cyc, got_err); else n_pass++;
    endtask

    task automatic test_backpressure();
        int held = 0;
        do_start(0, 3, 0, 0, 24'h123456, 1'b0);
        collect(1, 3);
        foreach (obs[i]) if (obs[i] == 1) held++;
        n_total++; if (wa.size() !== 4) $display("FAIL bp_count got=%0d exp=4", wa.size()); else n_pass++;
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            n_total++; if (wa[i] !== i) $display("FAIL bp_wr%0d got=%0d exp=%0d", i, wa[i], i); else n_pass++;
        end
        n_total++; if (held !== 4) $display("FAIL bp_hold got=%0d exp=4", held); else n_pass++;
        n_total++; if (done_cyc !== 7) $display("FAIL bp_done got=%0d exp=7", done_cyc); else n_pass++;
    endtask

    task automatic test_invalid();
        do_start(20, 10, 0, 0, 24'hFFFFFF, 1'b0);
        collect(-1, 0);
        n_total++; if (got_done !== 1'b1 || got_err !== 1'b1 || done_cyc !== 0) $display("FAIL inv_xorder got done=%0d err=%0d cyc=%0d exp=1/1/0", got_done, got_err, done_cyc); else n_pass++;
        n_total++; if (wa.size() !== 0 || busy_bad !== 1'b0) $display("FAIL inv_xorder_wr got=%0d busy_bad=%0d exp=0/0", wa.size(), busy_bad); else n_pass++;
        @(negedge CLOCK_50);
        n_total++; if ({done, err, busy} !== 3'b000) $display("FAIL inv_clear got=%b exp=000", {done, err, busy}); else n_pass++;
        do_start(0, 768, 0, 0, 24'hFFFFFF, 1'b0);
        collect(-1, 0);
        n_total++; if (got_err !== 1'b1 || done_cyc !== 0 || wa.size() !== 0) $display("FAIL inv_xmax got err=%0d cyc=%0d wr=%0d exp=1/0/0", got_err, done_cyc, wa.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        bit stray = 1'b0;
        do_start(0, 9, 0, 9, 24'h0000FF, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (wr_en && wr_addr == 19'd768) begin found = 1'b1; break; end
            @(negedge CLOCK_50);
        end
        n_total++; if (found !== 1'b1) $display("FAIL rmid_left got=%0d exp=1", found); else n_pass++;
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        n_total++; if ({wr_en, busy, done} !== 3'b000) $display("FAIL rmid_abort got=%b exp=000", {wr_en, busy, done}); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            if (wr_en || done || busy) stray = 1'b1;
        end
        n_total++; if (stray !== 1'b0) $display("FAIL rmid_resume got=%0d exp=0", stray); else n_pass++;
        do_start(1, 1, 1, 1, 24'h0000FF, 1'b0);
        collect(-1, 0);
        n_total++; if (wa.size() !== 1 || wa[0] !== 769) $display("FAIL rmid_next got n=%0d a=%0d exp=1/769", wa.size(), (wa.size() > 0) ? wa[0] : -1); else n_pass++;
    endtask

    task automatic test_reset_priority();
        @(negedge CLOCK_50);
        x_min = 10'd2; x_max = 10'd4; y_min = 9'd2; y_max = 9'd4;
        start = 1'b1; reset = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0; reset = 1'b0;
        n_total++; if ({wr_en, busy} !== 2'b00) $display("FAIL rprio_start got=%b exp=00", {wr_en, busy}); else n_pass++;
        @(negedge CLOCK_50);
        n_total++; if ({wr_en, busy, done} !== 3'b000) $display("FAIL rprio_idle got=%b exp=000", {wr_en, busy, done}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_start(0, 3, 0, 0, 24'hABCDEF, 1'b0);
        x_min = 10'd5; x_max = 10'd5; y_min = 9'd5; y_max = 9'd5; start = 1'b1;
        collect(-1, 0);
        n_total++; if (wa.size() !== 4) $display("FAIL busy_ign_count got=%0d exp=4", wa.size()); else n_pass++;
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            n_total++; if (wa[i] !== i || wd[i] !== 24'hABCDEF) $display("FAIL busy_ign_wr%0d got=%0d/%h exp=%0d/abcdef", i, wa[i], wd[i], i); else n_pass++;
        end
        n_total++; if (done_cyc !== 4) $display("FAIL busy_ign_done got=%0d exp=4", done_cyc); else n_pass++;
    endtask

    task automatic test_fill();
`ifdef BOX_DRAW_FILL_EN
        int exp_a[9] = '{0, 1, 2, 768, 769, 770, 1536, 1537, 1538};
        int n = 9;
`else
        int exp_a[9] = '{0, 1, 2, 1536, 1537, 1538, 768, 770, -1};
        int n = 8;
`endif
        do_start(0, 2, 0, 2, 24'h00FF00, 1'b1);
        collect(-1, 0);
        n_total++; if (wa.size() !== n) $display("FAIL fill_count got=%0d exp=%0d", wa.size(), n); else n_pass++;
        for (int i = 0; i < n && i < wa.size(); i++) begin
            n_total++; if (wa[i] !== exp_a[i]) $display("FAIL fill_wr%0d got=%0d exp=%0d", i, wa[i], exp_a[i]); else n_pass++;
        end
        n_total++; if (done_cyc !== n) $display("FAIL fill_done got=%0d exp=%0d", done_cyc, n); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_outline();
        test_single();
        test_backpressure();
        test_invalid();
        test_reset_mid();
        test_reset_priority();
        test_back_to_back();
        test_fill();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
